// File: rtl/lpc_mem_reader.sv
// lpc_mem_reader: drains one captured LPC frame slot from the capture RAM and
// streams its bytes to a downstream serializer over a valid/ready handshake.
//
// Optional build macro: LPC_READER_SYNC_MARKER_EN
//   When defined, each frame is preceded by the constant marker byte 0xA5.
//   No RAM read is issued for the marker.
//
// Stream handshake: out_data/out_valid are registered. Once out_valid rises,
// out_data stays stable and out_valid stays high until a posedge sees
// out_valid & out_ready. That posedge transfers the byte. out_ready has no
// effect while out_valid is low.
//
// debug_state exposes the FSM state encoding for checkers.
module lpc_mem_reader #(
  parameter int SLOT_BITS   = 5,
  parameter int FRAME_BYTES = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_available,
  input  logic [SLOT_BITS-1:0] source_slot,
  output logic [SLOT_BITS+2:0] ram_addr,
  output logic                 ram_read_en,
  input  logic [7:0]           ram_data,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_read_done,
  output logic                 busy,
  output logic [2:0]           debug_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4,
    S_MARKER = 3'd5
  } state_t;

  localparam logic [2:0] LAST_OFFSET = 3'(FRAME_BYTES - 1);

  state_t               state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [2:0]           offset_q, offset_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
`ifdef LPC_READER_SYNC_MARKER_EN
  // Set while the byte in SEND is the marker rather than RAM data.
  logic                 marker_q, marker_d;
`endif

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      slot_q      <= '0;
      offset_q    <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
`ifdef LPC_READER_SYNC_MARKER_EN
      marker_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      offset_q    <= offset_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef LPC_READER_SYNC_MARKER_EN
      marker_q    <= marker_d;
`endif
    end
  end

  // Next-state logic: one RAM read per byte, then hold the byte until accepted.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    offset_d    = offset_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef LPC_READER_SYNC_MARKER_EN
    marker_d    = marker_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_available) begin
          // The slot is latched once; later source_slot changes are ignored.
          slot_d   = source_slot;
          offset_d = '0;
`ifdef LPC_READER_SYNC_MARKER_EN
          state_d  = S_MARKER;
`else
          state_d  = S_READ;
`endif
        end
      end
      S_MARKER: begin
`ifdef LPC_READER_SYNC_MARKER_EN
        out_data_d  = 8'hA5;
        out_valid_d = 1'b1;
        marker_d    = 1'b1;
        state_d     = S_SEND;
`else
        state_d     = S_IDLE;
`endif
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // RAM data for the read issued in READ is valid in this cycle.
        out_data_d  = ram_data;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef LPC_READER_SYNC_MARKER_EN
          if (marker_q) begin
            marker_d = 1'b0;
            state_d  = S_READ;
          end else
`endif
          if (offset_q == LAST_OFFSET) begin
            state_d = S_DONE;
          end else begin
            offset_d = offset_q + 3'd1;
            state_d  = S_READ;
          end
        end
      end
      S_DONE: begin
        // Returning to IDLE gives the ringbuffer one cycle to update
        // frame_available before it is sampled again.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_addr        = {slot_q, offset_q};
  assign ram_read_en     = (state_q == S_READ);
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign frame_read_done = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE);
  assign debug_state     = state_q;

endmodule

// File: tb/tb_lpc_mem_reader.sv
// Testbench for lpc_mem_reader: RAM model, table-driven frame runs, and
// hand-written sequences for reset mid-frame and back-to-back frames.
module tb_lpc_mem_reader;

  localparam int SLOT_BITS   = 5;
  localparam int FRAME_BYTES = 6;
`ifdef LPC_READER_SYNC_MARKER_EN
  localparam int MARK = 1;
`else
  localparam int MARK = 0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 frame_available;
  logic [SLOT_BITS-1:0] source_slot;
  logic [SLOT_BITS+2:0] ram_addr;
  logic                 ram_read_en;
  logic [7:0]           ram_data;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 frame_read_done;
  logic                 busy;
  logic [2:0]           debug_state;

  lpc_mem_reader #(.SLOT_BITS(SLOT_BITS), .FRAME_BYTES(FRAME_BYTES)) dut (
    .clock(clock), .reset(reset), .frame_available(frame_available),
    .source_slot(source_slot), .ram_addr(ram_addr), .ram_read_en(ram_read_en),
    .ram_data(ram_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .frame_read_done(frame_read_done), .busy(busy),
    .debug_state(debug_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- RAM model ----------------
  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (ram_read_en) ram_data <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] addr_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  bit hold_pend = 0;
  logic [7:0] hold_data;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: inputs change only just after posedge, so the values seen at
  // negedge are the ones the next posedge samples.
  always @(negedge clock) begin
    if (reset) begin
      hold_pend = 0;
    end else begin
      if (ram_read_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) fail_now($sformatf("ram_read_unexpected addr=0x%0h expected none", ram_addr));
        else check("ram_addr", int'(ram_addr), int'(addr_q.pop_front()));
      end
      if (hold_pend) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(hold_data));
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) fail_now($sformatf("out_unexpected data=0x%0h expected none", out_data));
        else check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
      if (frame_read_done) done_cnt++;
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int slot);
    if (MARK != 0) exp_q.push_back(8'hA5);
    for (int o = 0; o < FRAME_BYTES; o++) begin
      exp_q.push_back(mem[slot*8 + o]);
      addr_q.push_back(8'(slot*8 + o));
    end
  endtask

  task automatic run_frame(input int row, input int slot, input int stall_idx,
                           input int stall_len, input int new_slot);
    int acc0, rd0, dn0, stall_left, cyc, done_cyc, first_valid;
    bit done_seen;
    acc0 = acc_cnt; rd0 = rd_cnt; dn0 = done_cnt;
    stall_left = stall_len; done_seen = 0; done_cyc = -1; first_valid = -1;
    push_frame(slot);
    source_slot = SLOT_BITS'(slot);
    frame_available = 1;
    out_ready = 1;
    for (cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      @(posedge clock); #1;
      frame_available = 0;
      if (cyc == 0) check($sformatf("row%0d_first_read_en", row), int'(ram_read_en), (MARK != 0) ? 0 : 1);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (new_slot >= 0 && acc_cnt - acc0 >= 1) source_slot = SLOT_BITS'(new_slot);
      if (out_valid && (acc_cnt - acc0 == stall_idx) && stall_left > 0) begin
        out_ready = 0;
        stall_left--;
      end else begin
        out_ready = 1;
      end
      if (frame_read_done) begin
        done_seen = 1;
        done_cyc = cyc;
      end
    end
    if (!done_seen) fail_now($sformatf("row%0d_timeout waiting for frame_read_done", row));
    check($sformatf("row%0d_latency", row), first_valid, (MARK != 0) ? 1 : 2);
    if (stall_len == 0)
      check($sformatf("row%0d_done_cycle", row), done_cyc, 3*FRAME_BYTES + 2*MARK);
    @(posedge clock); #1;
    check($sformatf("row%0d_busy_after_done", row), int'(busy), 0);
    check($sformatf("row%0d_done_single", row), int'(frame_read_done), 0);
    check($sformatf("row%0d_reads", row), rd_cnt - rd0, FRAME_BYTES);
    check($sformatf("row%0d_bytes", row), acc_cnt - acc0, FRAME_BYTES + MARK);
    check($sformatf("row%0d_done_cnt", row), done_cnt - dn0, 1);
    check($sformatf("row%0d_exp_left", row), exp_q.size() + addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int slot;
    int stall_idx;
    int stall_len;
    int new_slot;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, dn0, rd0, cyc;
    bit first_done;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[24] = 8'h0A; mem[25] = 8'h12; mem[26] = 8'h34;
    mem[27] = 8'h56; mem[28] = 8'h78; mem[29] = 8'h9C;

    vecs[0] = '{slot: 3,  stall_idx: -1,       stall_len: 0,  new_slot: -1};
    vecs[1] = '{slot: 3,  stall_idx: 2 + MARK, stall_len: 10, new_slot: -1};
    vecs[2] = '{slot: 31, stall_idx: -1,       stall_len: 0,  new_slot: 2};
    vecs[3] = '{slot: 7,  stall_idx: 0,        stall_len: 3,  new_slot: -1};
    vecs[4] = '{slot: 0,  stall_idx: 5 + MARK, stall_len: 4,  new_slot: -1};

    reset = 1; frame_available = 1; source_slot = 5'd9; out_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_ram_read_en", int'(ram_read_en), 0);
    check("rst_done", int'(frame_read_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    frame_available = 0;
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    check("idle_busy", int'(busy), 0);

    // Table-driven single frames.
    for (int r = 0; r < 5; r++)
      run_frame(r, vecs[r].slot, vecs[r].stall_idx, vecs[r].stall_len, vecs[r].new_slot);

    // Reset one cycle after the second byte is accepted; frame restarts.
    push_frame(3);
    acc0 = acc_cnt;
    source_slot = 5'd3; frame_available = 1; out_ready = 1;
    for (cyc = 0; cyc < 100 && (acc_cnt - acc0) < 2 + MARK; cyc++) begin
      @(posedge clock); #1;
    end
    if ((acc_cnt - acc0) < 2 + MARK) fail_now("rst_mid_timeout waiting for second byte");
    dn0 = done_cnt;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_out_data", int'(out_data), 0);
    check("rstmid_read_en", int'(ram_read_en), 0);
    check("rstmid_done", int'(frame_read_done), 0);
    check("rstmid_busy", int'(busy), 0);
    exp_q.delete();
    addr_q.delete();
    push_frame(3);
    acc0 = acc_cnt; rd0 = rd_cnt;
    for (cyc = 0; cyc < 100 && frame_available; cyc++) begin
      @(posedge clock); #1;
      if (frame_read_done) frame_available = 0;
    end
    @(posedge clock); #1;
    check("rstmid_done_cnt", done_cnt - dn0, 1);
    check("rstmid_restream_bytes", acc_cnt - acc0, FRAME_BYTES + MARK);
    check("rstmid_restream_reads", rd_cnt - rd0, FRAME_BYTES);
    check("rstmid_exp_left", exp_q.size() + addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();

    // Back-to-back frames with frame_available held high.
    push_frame(0);
    push_frame(1);
    dn0 = done_cnt; rd0 = rd_cnt;
    first_done = 0;
    source_slot = 5'd0; frame_available = 1; out_ready = 1;
    for (cyc = 0; cyc < 200 && frame_available; cyc++) begin
      @(posedge clock); #1;
      if (first_done) begin
        check("b2b_idle_gap_busy", int'(busy), 0);
        check("b2b_idle_gap_read", int'(ram_read_en), 0);
        first_done = 0;
      end
      if (frame_read_done) begin
        if (source_slot == 5'd0) begin
          source_slot = 5'd1;
          first_done = 1;
        end else begin
          frame_available = 0;
        end
      end
    end
    @(posedge clock); #1;
    check("b2b_done_cnt", done_cnt - dn0, 2);
    check("b2b_reads", rd_cnt - rd0, 2*FRAME_BYTES);
    check("b2b_exp_left", exp_q.size() + addr_q.size(), 0);
    repeat (3) @(posedge clock);
    #1;
    check("final_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
